// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver with start-glitch rejection, stop-bit
//            framing check and one-cycle valid strobe. Define UART_RX_PARITY_EN
//            to expect one parity bit after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iRX,
  output logic [DATA_BITS-1:0] oData,
  output logic                 oValid,
  output logic                 oFrameErr,
  output logic                 oParityErr,
  output logic                 oBusy
);

  localparam int c_CPB   = CLK_FREQ / BAUD;
  localparam int c_HALF  = c_CPB / 2;
  localparam int c_CNT_W = $clog2(c_CPB);
  localparam int c_IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CPB - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_HALF - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
  localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || c_CPB < 4) begin : g_param_check
      $error("uart_rx_param: illegal parameter set");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_stop_idx, w_stop_idx_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 w_done;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par_nxt;
`endif

  // Line synchronizer plus history flop; idle-high reset avoids a false edge.
  logic r_sync1, r_rx_s, r_rx_hist;
  logic w_fall;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_hist <= 1'b1;
    end else begin
      r_sync1   <= iRX;
      r_rx_s    <= r_sync1;
      r_rx_hist <= r_rx_s;
    end
  end

  assign w_fall = r_rx_hist & ~r_rx_s;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_stop_idx <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_stop_idx_nxt = r_stop_idx;
    w_ferr_nxt     = r_ferr;
    w_done         = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt      = r_par;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end
      // Half a bit into the start bit: still low means a real start.
      S_START: begin
        if (r_cnt == c_CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == c_IDX_LAST) begin
            w_stop_idx_nxt = 1'b0;
            w_ferr_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt    = S_PARITY;
`else
            w_state_nxt    = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_rx_s;
          w_state_nxt = S_STOP;
        end
      end
`endif
      // Leave at the middle of the last stop bit so a following start edge is seen.
      S_STOP: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt      = '0;
          w_ferr_nxt     = r_ferr | ~r_rx_s;
          w_stop_idx_nxt = r_stop_idx + 1'b1;
          if (r_stop_idx == c_STOP_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData     <= '0;
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oValid <= w_done;
      oBusy  <= (w_state_nxt != S_IDLE);
      if (w_done) begin
        oData     <= r_shift;
        oFrameErr <= w_ferr_nxt;
      end else if (oValid) begin
        oFrameErr <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oParityErr <= 1'b0;
    end else if (w_done) begin
      oParityErr <= (^r_shift) ^ r_par ^ 1'(PARITY_ODD);
    end else if (oValid) begin
      oParityErr <= 1'b0;
    end
  end
`else
  assign oParityErr = 1'b0;
`endif

endmodule
`default_nettype wire
